iexecute: RTL
=============

# iexecute

Execute stage of the 5-stage RISC-V pipeline. Consumes the ID/EX register outputs from the decode stage and resolves operand forwarding, ALU operation, branch/jump redirect and branch target. Registers the results into the EX/MEM pipeline register that feeds the memory stage.

## Interface
Parameters:
- `XLEN`, default 32: datapath width.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears EX/MEM register.
- `ValidE`  in  1  E-stage holds a real instruction (0 = bubble/flushed).
- `RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE`  in  1 each  ID/EX control.
- `ResultSrcE`  in  2  writeback source select, passed through.
- `ALUControlE`  in  3  ALU operation.
- `RdE`  in  5  destination register.
- `PCE, RD1E, RD2E, ImmExtE, PCPlus4E`  in  XLEN each  ID/EX data.
- `ForwardAE, ForwardBE`  in  2 each  operand source from the hazard unit: 00 = register file, 01 = `ResultW`, 10 = `ALUResultM`, 11 = register file.
- `ResultW`  in  XLEN  writeback-stage result, for forwarding.
- `PCSrcE`  out  1  redirect fetch (combinational).
- `PCTargetE`  out  XLEN  branch/jump target (combinational).
- `ValidM, RegWriteM, MemWriteM`  out  1 each  EX/MEM control.
- `ResultSrcM`  out  2.
- `RdM`  out  5.
- `ALUResultM, WriteDataM, PCPlus4M`  out  XLEN each.

## Operation
- SrcAE = mux(ForwardAE: RD1E, ResultW, ALUResultM, RD1E).
- WriteDataE = mux(ForwardBE, same sources over RD2E).
- SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU encoding (ALUControlE):
  - 000 add.
  - 001 sub.
  - 010 and.
  - 011 or.
  - 100 xor.
  - 101 slt: signed, result 1 or 0.
  - 110 sltu.
  - 111 result 0.
- Add/sub wrap modulo 2^XLEN; no overflow flag.
- ZeroE = (ALUResult == 0).
- PCTargetE = PCE + ImmExtE, wrapping.
- PCSrcE = ValidE & ((BranchE & ZeroE) | JumpE).
- EX/MEM register loads every cycle:
  - ValidM <= ValidE.
  - RegWriteM <= RegWriteE & ValidE.
  - MemWriteM <= MemWriteE & ValidE.
  - All data fields, ResultSrcM and RdM load unconditionally.
- A bubble (ValidE = 0) can never write the register file or memory and never redirects the PC.
- `ALUResultM` used for forwarding is the internal register output; a back-to-back dependent instruction sees the previous cycle's ALU result.

## Timing
- Reset values: every M-stage output is 0, including ValidM, RegWriteM, MemWriteM, ResultSrcM = 00, RdM = 0, and all data fields.
- Reset is asynchronous: outputs clear immediately on assertion, mid-instruction included. The first capture occurs on the first rising edge after deassertion.
- PCSrcE and PCTargetE are combinational from E-stage inputs, with zero-cycle latency. The hazard unit uses them in the same cycle to flush D/E.
- EX/MEM latency is one cycle: values presented in cycle N appear on M outputs after edge N+1.
- There is no stall input. The EX/MEM register never holds; stalls are bubbles injected upstream via ValidE.
- Simultaneous conditions:
  - BranchE and JumpE both set: redirect; the target is still PCE + ImmExtE.
  - ForwardAE = ForwardBE = 10: both operands take ALUResultM.
- RdE = 0 is passed through unchanged. The register file ignores writes to x0.

## Structure
- Shared package `riscv_pkg` holds:
  - ALU op constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU.
  - Forward-select constants: FWD_RF, FWD_WB, FWD_MEM.
  - ResultSrc encodings.
- Sub-module `alu` (combinational): inputs a, b, ALUControl; outputs result and zero.
- Sub-module `ex_mem`: the EX/MEM pipeline register with async reset, mirroring the existing ID/EX register style.
- `iexecute` itself contains only the forwarding muxes, SrcB mux, target adder, PCSrc logic and valid gating.

## Test plan
- Reset: assert reset mid-stream with ValidE = 1 and RegWriteE = 1 → all M outputs 0 immediately. After release, the first edge captures the current E inputs.
- ALU: RD1E = 0x7FFFFFFF, ImmExtE = 1, ALUSrcE = 1, add → ALUResultM = 0x80000000.
  - Same inputs with slt of 0x80000000 vs 1 → 1.
  - Same inputs with sltu → 0.
- Branch: BranchE = 1, sub, RD1E = RD2E = 5, PCE = 0x100, ImmExtE = 0xFFFFFFF8 → PCSrcE = 1 and PCTargetE = 0xF8 in the same cycle.
  - With ValidE = 0 → PCSrcE = 0.
- Forwarding: two back-to-back adds where the second has ForwardAE = 10 → SrcA equals the prior ALUResultM.
  - ForwardBE = 01 with ResultW = 0xDEAD → WriteDataM = 0xDEAD.
  - Forward select 11 → RD1E/RD2E used.
- Bubble: ValidE = 0 with RegWriteE = MemWriteE = 1 → ValidM = RegWriteM = MemWriteM = 0 after the edge.
- Jump: JumpE = 1, PCPlus4E = 0x24 → PCSrcE = 1, and PCPlus4M = 0x24 next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU ops, forwarding selects,
// writeback sources and the EX/MEM control bundle.
package riscv_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } resultSrc_t;

  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic       memWrite;
    logic [1:0] resultSrc;
    logic [4:0] rd;
  } exMemCtrl_t;

endpackage

// File: rtl/iexecute_if.sv
// ID/EX inputs, forwarding sources and EX/MEM outputs
// of the execute stage.
interface iexecute_if #(parameter int XLEN = 32);

  logic            ValidE;
  logic            RegWriteE;
  logic            MemWriteE;
  logic            JumpE;
  logic            BranchE;
  logic            ALUSrcE;
  logic [1:0]      ResultSrcE;
  logic [2:0]      ALUControlE;
  logic [4:0]      RdE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [XLEN-1:0] PCPlus4E;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;

  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;

  logic            ValidM;
  logic            RegWriteM;
  logic            MemWriteM;
  logic [1:0]      ResultSrcM;
  logic [4:0]      RdM;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;

  modport master (
    output ValidE, RegWriteE, MemWriteE,
    output JumpE, BranchE, ALUSrcE,
    output ResultSrcE, ALUControlE, RdE,
    output PCE, RD1E, RD2E,
    output ImmExtE, PCPlus4E,
    output ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE,
    input  ValidM, RegWriteM, MemWriteM,
    input  ResultSrcM, RdM,
    input  ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  ValidE, RegWriteE, MemWriteE,
    input  JumpE, BranchE, ALUSrcE,
    input  ResultSrcE, ALUControlE, RdE,
    input  PCE, RD1E, RD2E,
    input  ImmExtE, PCPlus4E,
    input  ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE,
    output ValidM, RegWriteM, MemWriteM,
    output ResultSrcM, RdM,
    output ALUResultM, WriteDataM, PCPlus4M
  );

endinterface

// File: rtl/alu.sv
// Combinational integer ALU for the execute stage.
// Add/sub wrap; unused encoding yields zero.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic lt;
  logic ltu;

  assign lt  = $signed(a) < $signed(b);
  assign ltu = a < b;

  always_comb begin
    result = '0;
    case (ALUControl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register; loads every cycle,
// cleared asynchronously by reset.
module ex_mem
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  exMemCtrl_t      ctrlE,
  input  logic [XLEN-1:0] aluResultE,
  input  logic [XLEN-1:0] writeDataE,
  input  logic [XLEN-1:0] pcPlus4E,
  output exMemCtrl_t      ctrlM,
  output logic [XLEN-1:0] aluResultM,
  output logic [XLEN-1:0] writeDataM,
  output logic [XLEN-1:0] pcPlus4M
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrlM      <= '0;
      aluResultM <= '0;
      writeDataM <= '0;
      pcPlus4M   <= '0;
    end else begin
      ctrlM      <= ctrlE;
      aluResultM <= aluResultE;
      writeDataM <= writeDataE;
      pcPlus4M   <= pcPlus4E;
    end
  end

endmodule

// File: rtl/iexecute.sv
// Execute stage: operand forwarding, ALU, branch/jump
// redirect and target, feeding the EX/MEM register.
module iexecute
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     reset,
  iexecute_if.slave ex
);

  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic [XLEN-1:0] writeDataE;
  logic [XLEN-1:0] aluResultE;
  logic [XLEN-1:0] aluResultM;
  logic [XLEN-1:0] writeDataM;
  logic [XLEN-1:0] pcPlus4M;
  logic            zeroE;
  exMemCtrl_t      ctrlE;
  exMemCtrl_t      ctrlM;

  // Select 11 is treated like 00: register file
  always_comb begin
    case (ex.ForwardAE)
      FWD_WB:  srcA = ex.ResultW;
      FWD_MEM: srcA = aluResultM;
      default: srcA = ex.RD1E;
    endcase
  end

  always_comb begin
    case (ex.ForwardBE)
      FWD_WB:  writeDataE = ex.ResultW;
      FWD_MEM: writeDataE = aluResultM;
      default: writeDataE = ex.RD2E;
    endcase
  end

  assign srcB = ex.ALUSrcE ? ex.ImmExtE
                           : writeDataE;

  alu #(.XLEN(XLEN)) uAlu (
    .a          (srcA),
    .b          (srcB),
    .ALUControl (ex.ALUControlE),
    .result     (aluResultE),
    .zero       (zeroE)
  );

  assign ex.PCTargetE = ex.PCE + ex.ImmExtE;
  assign ex.PCSrcE    = ex.ValidE &
    ((ex.BranchE & zeroE) | ex.JumpE);

  // Bubbles must never write the RF or memory
  assign ctrlE.valid     = ex.ValidE;
  assign ctrlE.regWrite  = ex.RegWriteE & ex.ValidE;
  assign ctrlE.memWrite  = ex.MemWriteE & ex.ValidE;
  assign ctrlE.resultSrc = ex.ResultSrcE;
  assign ctrlE.rd        = ex.RdE;

  ex_mem #(.XLEN(XLEN)) uExMem (
    .clk        (clk),
    .reset      (reset),
    .ctrlE      (ctrlE),
    .aluResultE (aluResultE),
    .writeDataE (writeDataE),
    .pcPlus4E   (ex.PCPlus4E),
    .ctrlM      (ctrlM),
    .aluResultM (aluResultM),
    .writeDataM (writeDataM),
    .pcPlus4M   (pcPlus4M)
  );

  assign ex.ValidM     = ctrlM.valid;
  assign ex.RegWriteM  = ctrlM.regWrite;
  assign ex.MemWriteM  = ctrlM.memWrite;
  assign ex.ResultSrcM = ctrlM.resultSrc;
  assign ex.RdM        = ctrlM.rd;
  assign ex.ALUResultM = aluResultM;
  assign ex.WriteDataM = writeDataM;
  assign ex.PCPlus4M   = pcPlus4M;

endmodule
